adc_scan_sequencer: RTL
=======================

Name: adc_scan_sequencer

Overview:
- Parametrised multi-channel scan controller for the GW5A ADC in vsenctl loc_left mode.
- Sweeps up to NUM_CH TLVDS_IBUF_ADC inputs by one-hot driving their ADCEN pins.
- Handles settling, request/ready handshake, per-channel averaging, timeout detection and single-shot or continuous scanning.
- Sits between the Gowin_ADC IP (adcreqi/adcrdy/adcvalue) and downstream consumers of per-channel results.

Parameters:
- NUM_CH, 5: number of analog channels, 1..8.
- DATA_W, 14: ADC sample width.
- AVG_LOG2, 2: log2 of samples averaged per channel, 0..4.
- SETTLE_CYC, 64: clk cycles after a channel switch before the first request, >=1.
- GAP_CYC, 16: minimum clk cycles o_adc_req stays low between requests, >=1.
- TIMEOUT_CYC, 65535: maximum clk cycles waiting for ready per request.
- CH_W: localparam, max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  system clock (50 MHz).
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle pulse that starts a scan.
- i_continuous  in  1  1 = restart the scan after the last channel.
- i_ch_mask  in  NUM_CH  channel enable; bit k = channel k.
- o_adc_req  out  1  to Gowin_ADC adcreqi.
- i_adc_ready  in  1  Gowin_ADC adcrdy, asynchronous to clk.
- i_adc_value  in  DATA_W  Gowin_ADC adcvalue.
- o_adc_sel  out  NUM_CH  one-hot, to TLVDS_IBUF_ADC ADCEN[k].
- o_sample_valid  out  1  one-cycle pulse when a channel result is ready.
- o_sample_ch  out  CH_W  channel index of that result.
- o_sample_data  out  DATA_W  averaged result.
- o_results  out  NUM_CH*DATA_W  latest result per channel; channel k occupies bits [k*DATA_W +: DATA_W].
- o_busy  out  1  high whenever the state is not IDLE.
- o_error  out  1  sticky timeout flag.

Behaviour:
- Reset values:
  - All outputs 0.
  - o_results cleared.
  - State IDLE.
  - Synchroniser flops 0.
- i_adc_ready handling:
  - Passes through a 2-FF synchroniser plus edge detector.
  - "rdy_edge" = synchronised 0->1 transition.
  - i_adc_value is sampled on the rdy_edge cycle; it is stable while adcrdy is high.
- States:
  - IDLE: o_adc_sel=0, o_adc_req=0. On i_start with i_ch_mask != 0: latch mask into scan_mask, clear o_error, go to SELECT. i_start with mask=0 is ignored. i_start is ignored in every other state.
  - SELECT: pick the lowest enabled channel index above the previous one; the first selection of a scan picks the lowest enabled index. Set o_adc_sel to its one-hot, clear accumulator and sample count, go to SETTLE. One cycle.
  - SETTLE: count SETTLE_CYC cycles, then go to CONVERT.
  - CONVERT: o_adc_req=1; timeout counter runs.
    - On rdy_edge: acc += i_adc_value, o_adc_req=0, go to GAP.
    - If the counter reaches TIMEOUT_CYC before rdy_edge: set o_error, o_adc_req=0, abandon the channel with no valid pulse and o_results unchanged, go to NEXT.
  - GAP: hold o_adc_req=0 for GAP_CYC cycles. Then, if count < 2^AVG_LOG2, go to CONVERT; otherwise go to DONE.
  - DONE: one cycle. Result = acc >> AVG_LOG2, truncated. Pulse o_sample_valid, drive o_sample_ch/o_sample_data, update the matching slice of o_results, go to NEXT.
  - NEXT: if an enabled channel with a higher index remains in scan_mask, go to SELECT. Otherwise:
    - i_continuous=1: re-latch i_ch_mask. If the new mask is nonzero, go to SELECT starting from the lowest index; if zero, go to IDLE.
    - i_continuous=0: go to IDLE.
- Data widths:
  - Accumulator width DATA_W+AVG_LOG2; it cannot overflow.
  - AVG_LOG2=0 gives the raw sample.
- o_sample_ch/o_sample_data hold their values until the next DONE.
- o_adc_sel changes only in SELECT and IDLE. It is never multi-hot, and is held through SETTLE/CONVERT/GAP.
- Changes on i_ch_mask mid-scan have no effect until the next scan latch.
- i_reset mid-operation returns to reset values in the next cycle: o_adc_req and o_adc_sel drop immediately and the partial accumulation is discarded.
- Latency per channel ≈ 1 + SETTLE_CYC + 2^AVG_LOG2 × (conversion + 3 sync + GAP_CYC) + 2 cycles.

Test Plan:
- NUM_CH=5, AVG_LOG2=0, SETTLE_CYC=4, GAP_CYC=2; mask=5'b10101; i_start; ADC model returns 100×(ch+1) -> valids on ch0/2/4 with data 100/300/500; o_adc_sel sequence 00001, 00100, 10000, then 0; o_busy drops.
- AVG_LOG2=2; channel 1 only; model returns 10, 11, 12, 14 -> a single valid with data 11 (47>>2); exactly 4 req pulses, each separated by >=2 low cycles.
- TIMEOUT_CYC=100; mask=5'b00011; model never raises ready on ch0 -> o_error=1 at cycle ~100 after req; no valid for ch0; ch1 converts normally; o_results[ch0] unchanged.
- Continuous mode; mask=5'b00010, later changed to 5'b01000 mid-scan -> current scan completes on ch1 only, next scan uses ch3; dropping i_continuous ends the scan and returns to IDLE.
- mask=0 with i_start -> stays IDLE, o_busy=0. i_start during CONVERT -> ignored, no restart.
- Assert i_reset during CONVERT -> next cycle o_adc_req=0, o_adc_sel=0, o_results=0, o_busy=0. A fresh i_start then scans normally.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// Multi-channel scan controller for the GW5A ADC: one-hot channel select, settling,
// request/ready handshake, per-channel averaging, timeout detection, single/continuous scan.
module adc_scan_sequencer #(
    parameter int NUM_CH      = 5,
    parameter int DATA_W      = 14,
    parameter int AVG_LOG2    = 2,
    parameter int SETTLE_CYC  = 64,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 65535,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic                     i_continuous,
    input  logic [NUM_CH-1:0]        i_ch_mask,
    output logic                     o_adc_req,
    input  logic                     i_adc_ready,
    input  logic [DATA_W-1:0]        i_adc_value,
    output logic [NUM_CH-1:0]        o_adc_sel,
    output logic                     o_sample_valid,
    output logic [CH_W-1:0]          o_sample_ch,
    output logic [DATA_W-1:0]        o_sample_data,
    output logic [NUM_CH*DATA_W-1:0] o_results,
    output logic                     o_busy,
    output logic                     o_error
);

    localparam int ACC_W    = DATA_W + AVG_LOG2;
    localparam int SMP_W    = AVG_LOG2 + 1;
    localparam int CNT_MAX0 = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
    localparam int CNT_MAX  = (TIMEOUT_CYC > CNT_MAX0) ? TIMEOUT_CYC : CNT_MAX0;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_CONVERT,
        S_GAP,
        S_DONE,
        S_NEXT
    } state_e;

    // Returns {found, index} of the lowest enabled channel, either from zero or above cur.
    function automatic logic [CH_W:0] find_next(input logic [NUM_CH-1:0] mask,
                                                input logic [CH_W-1:0]   cur,
                                                input logic              from_start);
        logic [CH_W:0] res;
        res = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask[k] && (from_start || (k > int'(cur)))) begin
                res = {1'b1, CH_W'(k)};
            end
        end
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] avg_result(input logic [ACC_W-1:0] acc);
        return DATA_W'(acc >> AVG_LOG2);
    endfunction

    state_e                  state_q, state_d;
    logic [NUM_CH-1:0]       scan_mask_q, scan_mask_d;
    logic [CH_W-1:0]         cur_ch_q, cur_ch_d;
    logic                    first_q, first_d;
    logic [NUM_CH-1:0]       sel_q, sel_d;
    logic                    req_q, req_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SMP_W-1:0]        smp_q, smp_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    valid_q, valid_d;
    logic [CH_W-1:0]         sample_ch_q, sample_ch_d;
    logic [DATA_W-1:0]       sample_data_q, sample_data_d;
    logic [NUM_CH*DATA_W-1:0] results_q, results_d;
    logic                    error_q, error_d;
    logic                    rdy_meta_q, rdy_meta_d;
    logic                    rdy_sync_q, rdy_sync_d;
    logic                    rdy_prev_q, rdy_prev_d;

    logic                    rdy_edge;
    logic [CH_W:0]           nxt;
    logic                    nxt_found;
    logic [CH_W-1:0]         nxt_idx;

    assign rdy_edge  = rdy_sync_q & ~rdy_prev_q;
    assign nxt       = find_next(scan_mask_q, cur_ch_q, first_q);
    assign nxt_found = nxt[CH_W];
    assign nxt_idx   = nxt[CH_W-1:0];

    always_comb begin
        state_d       = state_q;
        scan_mask_d   = scan_mask_q;
        cur_ch_d      = cur_ch_q;
        first_d       = first_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        smp_d         = smp_q;
        acc_d         = acc_q;
        valid_d       = 1'b0;
        sample_ch_d   = sample_ch_q;
        sample_data_d = sample_data_q;
        results_d     = results_q;
        error_d       = error_q;
        rdy_meta_d    = i_adc_ready;
        rdy_sync_d    = rdy_meta_q;
        rdy_prev_d    = rdy_sync_q;

        case (state_q)
            S_IDLE: begin
                if (i_start && (|i_ch_mask)) begin
                    scan_mask_d = i_ch_mask;
                    error_d     = 1'b0;
                    first_d     = 1'b1;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                cur_ch_d = nxt_idx;
                sel_d    = NUM_CH'(1) << nxt_idx;
                first_d  = 1'b0;
                acc_d    = '0;
                smp_d    = '0;
                cnt_d    = '0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_CONVERT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_CONVERT: begin
                if (rdy_edge) begin
                    acc_d   = acc_q + ACC_W'(i_adc_value);
                    smp_d   = smp_q + SMP_W'(1);
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Abandon the channel: no result, previous o_results slice kept.
                    error_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = (smp_q < SMP_W'(1 << AVG_LOG2)) ? S_CONVERT : S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                valid_d       = 1'b1;
                sample_ch_d   = cur_ch_q;
                sample_data_d = avg_result(acc_q);
                results_d[int'(cur_ch_q)*DATA_W +: DATA_W] = avg_result(acc_q);
                state_d       = S_NEXT;
            end
            S_NEXT: begin
                if (nxt_found) begin
                    state_d = S_SELECT;
                end else if (i_continuous) begin
                    scan_mask_d = i_ch_mask;
                    if (|i_ch_mask) begin
                        first_d = 1'b1;
                        state_d = S_SELECT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_d = (state_d == S_CONVERT);
        if (state_d == S_IDLE) begin
            sel_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q       <= S_IDLE;
            scan_mask_q   <= '0;
            cur_ch_q      <= '0;
            first_q       <= 1'b0;
            sel_q         <= '0;
            req_q         <= 1'b0;
            cnt_q         <= '0;
            smp_q         <= '0;
            acc_q         <= '0;
            valid_q       <= 1'b0;
            sample_ch_q   <= '0;
            sample_data_q <= '0;
            results_q     <= '0;
            error_q       <= 1'b0;
            rdy_meta_q    <= 1'b0;
            rdy_sync_q    <= 1'b0;
            rdy_prev_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            scan_mask_q   <= scan_mask_d;
            cur_ch_q      <= cur_ch_d;
            first_q       <= first_d;
            sel_q         <= sel_d;
            req_q         <= req_d;
            cnt_q         <= cnt_d;
            smp_q         <= smp_d;
            acc_q         <= acc_d;
            valid_q       <= valid_d;
            sample_ch_q   <= sample_ch_d;
            sample_data_q <= sample_data_d;
            results_q     <= results_d;
            error_q       <= error_d;
            rdy_meta_q    <= rdy_meta_d;
            rdy_sync_q    <= rdy_sync_d;
            rdy_prev_q    <= rdy_prev_d;
        end
    end

    assign o_adc_req      = req_q;
    assign o_adc_sel      = sel_q;
    assign o_sample_valid = valid_q;
    assign o_sample_ch    = sample_ch_q;
    assign o_sample_data  = sample_data_q;
    assign o_results      = results_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_error        = error_q;

endmodule
